// File: rtl/apb_cmd_master.sv
// ----------------------------------------------------------------------------
// apb_cmd_master
//   Host-side APB4 requester. Turns a single valid/ready command (read or
//   write) into one two-phase APB transfer and returns a buffered response.
//   Write commands are held off while the downstream accelerator is busy;
//   an ACCESS phase that waits too long for pready_i is aborted.
//
// Ports
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake
//   cmd_write_i, cmd_addr_i,
//   cmd_wdata_i, cmd_strb_i    command payload
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_rdata_o, rsp_err_o,
//   rsp_timeout_o              response payload
//   psel_o .. pstrb_o          registered APB requester outputs
//   prdata_i, pready_i,
//   pslverr_i                  APB completer inputs
//   busy_i                     accelerator busy, stalls writes in IDLE
//   idle_o                     FSM is in IDLE
// ----------------------------------------------------------------------------
module apb_cmd_master #(
    parameter int DATA_WIDTH     = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]           cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]            cmd_wdata_i,
    input  logic [BUS_WIDTH/DATA_WIDTH-1:0] cmd_strb_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [BUS_WIDTH-1:0]            rsp_rdata_o,
    output logic                            rsp_err_o,
    output logic                            rsp_timeout_o,
    output logic                            psel_o,
    output logic                            penable_o,
    output logic                            pwrite_o,
    output logic [ADDR_WIDTH-1:0]           paddr_o,
    output logic [BUS_WIDTH-1:0]            pwdata_o,
    output logic [BUS_WIDTH/DATA_WIDTH-1:0] pstrb_o,
    input  logic [BUS_WIDTH-1:0]            prdata_i,
    input  logic                            pready_i,
    input  logic                            pslverr_i,
    input  logic                            busy_i,
    output logic                            idle_o
);

    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;

    // Counter value seen in the last permitted wait cycle; a wait in that
    // cycle makes the count reach TIMEOUT_CYCLES and aborts the transfer.
    localparam logic [15:0] WAIT_LAST =
        (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [ADDR_WIDTH-1:0]  r_paddr;
    logic [BUS_WIDTH-1:0]   r_pwdata;
    logic [MAX_DIM-1:0]     r_pstrb;
    logic                   r_rsp_valid;
    logic [BUS_WIDTH-1:0]   r_rsp_rdata;
    logic                   r_rsp_err;
    logic                   r_rsp_timeout;
    logic [15:0]            r_wait_cnt;

    logic                   w_cmd_ready;
    logic                   w_accept;
    logic                   w_timeout_hit;

    // Reads bypass the busy stall so status can be polled during a job.
    assign w_cmd_ready   = (r_state == ST_IDLE) && !(busy_i && cmd_write_i);
    assign w_accept      = cmd_valid_i && w_cmd_ready;

    // pready_i in the limit cycle completes normally, so it gates the abort.
    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_state == ST_ACCESS) &&
                           !pready_i && (r_wait_cnt == WAIT_LAST);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)                  w_state_nxt = ST_SETUP;
            ST_SETUP:                                 w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (pready_i || w_timeout_hit) w_state_nxt = ST_RESP;
            ST_RESP:   if (rsp_ready_i)               w_state_nxt = ST_IDLE;
            default:                                  w_state_nxt = ST_IDLE;
        endcase
    end

    // -------------------------------------------------- registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= cmd_write_i;
                        r_paddr   <= cmd_addr_i;
                        r_pwdata  <= cmd_wdata_i;
                        r_pstrb   <= cmd_write_i ? cmd_strb_i : '0;
                    end
                end
                ST_SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                end
                ST_ACCESS: begin
                    if (pready_i) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_pwrite ? '0 : prdata_i;
                        r_rsp_err     <= pslverr_i;
                        r_rsp_timeout <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready_o   = w_cmd_ready;
    assign idle_o        = (r_state == ST_IDLE);
    assign psel_o        = r_psel;
    assign penable_o     = r_penable;
    assign pwrite_o      = r_pwrite;
    assign paddr_o       = r_paddr;
    assign pwdata_o      = r_pwdata;
    assign pstrb_o       = r_pstrb;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// ----------------------------------------------------------------------------
// tb_apb_cmd_master
//   Bench for apb_cmd_master. A table of directed transfers and a batch of
//   random transfers are applied; expected responses and phase lengths come
//   from the transfer-level rules of the block. A second instance with the
//   timeout disabled covers the long-wait case; a reset pulse during ACCESS
//   is exercised by hand.
// ----------------------------------------------------------------------------
module tb_apb_cmd_master;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_ready;
    logic [31:0] prdata;
    logic        pready, pslverr, busy;

    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite, idle;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    // second instance, timeout disabled
    logic        b_cmd_valid, b_pready, b_rsp_ready;
    logic        b_cmd_ready, b_rsp_valid, b_rsp_err, b_rsp_timeout;
    logic [31:0] b_rsp_rdata;
    logic        b_psel, b_penable, b_pwrite, b_idle;
    logic [15:0] b_paddr;
    logic [31:0] b_pwdata;
    logic [3:0]  b_pstrb;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    apb_cmd_master #(
        .DATA_WIDTH(8), .BUS_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr),
        .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .rsp_timeout_o(rsp_timeout),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .paddr_o(paddr), .pwdata_o(pwdata), .pstrb_o(pstrb),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr),
        .busy_i(busy), .idle_o(idle)
    );

    apb_cmd_master #(
        .DATA_WIDTH(8), .BUS_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(0)
    ) dut_nto (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_cmd_ready),
        .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr),
        .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
        .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err),
        .rsp_timeout_o(b_rsp_timeout),
        .psel_o(b_psel), .penable_o(b_penable), .pwrite_o(b_pwrite),
        .paddr_o(b_paddr), .pwdata_o(b_pwdata), .pstrb_o(b_pstrb),
        .prdata_i(prdata), .pready_i(b_pready), .pslverr_i(pslverr),
        .busy_i(busy), .idle_o(b_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          busy;       // write: stalled 3 cycles; read: busy all along
        int unsigned waits;      // ACCESS cycles with pready low before ready
        logic [31:0] prdata;
        bit          slverr;
        int unsigned hold;       // cycles rsp_ready stays low in RESP
        int unsigned exp_access; // ACCESS-phase length in cycles
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_to;
    } xfer_t;

    function automatic xfer_t mk(input bit wr, input logic [15:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 input bit bsy, input int unsigned waits,
                                 input logic [31:0] prd, input bit slverr,
                                 input int unsigned hold, input int unsigned exp_access,
                                 input logic [31:0] exp_rdata, input bit exp_err,
                                 input bit exp_to);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.wdata = wdata; x.strb = strb; x.busy = bsy;
        x.waits = waits; x.prdata = prd; x.slverr = slverr; x.hold = hold;
        x.exp_access = exp_access; x.exp_rdata = exp_rdata;
        x.exp_err = exp_err; x.exp_to = exp_to;
        return x;
    endfunction

    // Reference outcome of one transfer from its stimulus.
    function automatic xfer_t model(input xfer_t x);
        xfer_t r = x;
        if (x.waits >= TO) begin
            r.exp_access = TO;
            r.exp_rdata  = 32'h0;
            r.exp_err    = 1'b1;
            r.exp_to     = 1'b1;
        end else begin
            r.exp_access = x.waits + 1;
            r.exp_rdata  = x.wr ? 32'h0 : x.prdata;
            r.exp_err    = x.slverr;
            r.exp_to     = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic run_xfer(input xfer_t x);
        logic [3:0] exp_strb;
        exp_strb = x.wr ? x.strb : 4'h0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = x.wr; cmd_addr = x.addr;
        cmd_wdata = x.wdata; cmd_strb = x.strb; busy = x.busy;
        pready = 1'b0; pslverr = 1'b0; rsp_ready = 1'b0; prdata = $urandom;
        if (x.busy && x.wr) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("stall_cmd_ready", cmd_ready, 0);
                chk("stall_psel", psel, 0);
                @(posedge clk); #1;
            end
            busy = 1'b0;
        end
        @(negedge clk);
        chk("accept_cmd_ready", cmd_ready, 1);
        chk("accept_idle", idle, 1);
        @(posedge clk); #1;
        // command payload is free to change once accepted
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 16'($urandom);
        cmd_wdata = $urandom; cmd_strb = 4'($urandom);
        @(negedge clk);
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_pwrite", pwrite, x.wr);
        chk("setup_paddr", paddr, x.addr);
        chk("setup_pwdata", pwdata, x.wdata);
        chk("setup_pstrb", pstrb, exp_strb);
        chk("setup_idle", idle, 0);
        @(posedge clk); #1;
        for (int k = 0; k < int'(x.exp_access); k++) begin
            pready  = (k == int'(x.waits));
            pslverr = pready ? x.slverr : 1'($urandom);
            prdata  = pready ? x.prdata : $urandom;
            @(negedge clk);
            chk("access_psel", psel, 1);
            chk("access_penable", penable, 1);
            chk("access_paddr", paddr, x.addr);
            chk("access_pwdata", pwdata, x.wdata);
            chk("access_pstrb", pstrb, exp_strb);
            chk("access_rsp_valid", rsp_valid, 0);
            @(posedge clk); #1;
        end
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
        for (int h = 0; h <= int'(x.hold); h++) begin
            // offer a read during RESP; it must not be taken
            cmd_valid = (h != int'(x.hold)); cmd_write = 1'b0;
            rsp_ready = (h == int'(x.hold));
            @(negedge clk);
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_rdata", rsp_rdata, x.exp_rdata);
            chk("rsp_err", rsp_err, x.exp_err);
            chk("rsp_timeout", rsp_timeout, x.exp_to);
            chk("rsp_psel", psel, 0);
            chk("rsp_penable", penable, 0);
            chk("rsp_cmd_ready", cmd_ready, 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0; busy = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_idle", idle, 1);
        chk("done_psel", psel, 0);
        chk("done_paddr_held", paddr, x.addr);
        chk("done_pwdata_held", pwdata, x.wdata);
        chk("done_pwrite_held", pwrite, x.wr);
    endtask

    xfer_t tbl[9];
    xfer_t rx;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0; prdata = '0;
        pready = 1'b0; pslverr = 1'b0; busy = 1'b0;
        b_cmd_valid = 1'b0; b_pready = 1'b0; b_rsp_ready = 1'b0;

        //           wr addr     wdata         strb  bsy wt prdata        err hold acc rdata         err to
        tbl[0] = mk(1, 16'h0010, 32'hA5A5_1234, 4'hF, 0,  0, 32'h0,        0,  0,   1, 32'h0,         0, 0);
        tbl[1] = mk(0, 16'h0000, 32'h1111_2222, 4'hF, 0,  3, 32'h0000_0001,0,  0,   4, 32'h0000_0001, 0, 0);
        tbl[2] = mk(1, 16'h0020, 32'hDEAD_BEEF, 4'h3, 1,  0, 32'h0,        0,  1,   1, 32'h0,         0, 0);
        tbl[3] = mk(0, 16'h0004, 32'h0,         4'hF, 1,  0, 32'h1234_5678,0,  0,   1, 32'h1234_5678, 0, 0);
        tbl[4] = mk(1, 16'h0030, 32'h0BAD_F00D, 4'h5, 0, 16, 32'hFFFF_FFFF,0,  0,  16, 32'h0,         1, 1);
        tbl[5] = mk(1, 16'h0040, 32'h0000_00FF, 4'h1, 0,  0, 32'h0,        1,  5,   1, 32'h0,         1, 0);
        tbl[6] = mk(0, 16'h0050, 32'h0,         4'hA, 0, 15, 32'hCAFE_F00D,0,  0,  16, 32'hCAFE_F00D, 0, 0);
        tbl[7] = mk(0, 16'h0060, 32'h0,         4'h0, 0, 20, 32'h7777_7777,0,  2,  16, 32'h0,         1, 1);
        tbl[8] = mk(0, 16'hFFFC, 32'h0,         4'hF, 0,  2, 32'h55AA_55AA,1,  0,   3, 32'h55AA_55AA, 1, 0);

        #12;
        chk("reset_psel", psel, 0);
        chk("reset_penable", penable, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_paddr", paddr, 0);
        chk("reset_pstrb", pstrb, 0);
        chk("reset_rsp_err", rsp_err, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", idle, 1);

        for (int i = 0; i < 9; i++) run_xfer(tbl[i]);

        // reset pulse during ACCESS
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0044;
        @(posedge clk); #1; cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_penable", penable, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_psel", psel, 0);
        chk("async_rst_penable", penable, 0);
        chk("async_rst_rsp_valid", rsp_valid, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after_rst_idle", idle, 1);
            chk("after_rst_psel", psel, 0);
            chk("after_rst_rsp_valid", rsp_valid, 0);
        end
        run_xfer(tbl[1]);

        // timeout disabled: long wait never aborts
        @(posedge clk); #1;
        b_cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0008; pslverr = 1'b0;
        @(posedge clk); #1; b_cmd_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("nto_wait", {29'h0, b_psel, b_penable, b_rsp_valid}, 32'h6);
            @(posedge clk); #1;
        end
        b_pready = 1'b1; prdata = 32'h0000_0077;
        @(posedge clk); #1; b_pready = 1'b0;
        @(negedge clk);
        chk("nto_rsp_valid", b_rsp_valid, 1);
        chk("nto_rsp_timeout", b_rsp_timeout, 0);
        chk("nto_rsp_err", b_rsp_err, 0);
        chk("nto_rsp_rdata", b_rsp_rdata, 32'h77);
        b_rsp_ready = 1'b1;
        @(posedge clk); #1; b_rsp_ready = 1'b0;
        @(negedge clk);
        chk("nto_idle", b_idle, 1);

        // random transfers against the reference outcome
        for (int n = 0; n < 40; n++) begin
            rx.wr     = 1'($urandom);
            rx.addr   = 16'($urandom);
            rx.wdata  = $urandom;
            rx.strb   = 4'($urandom);
            rx.busy   = ($urandom_range(0, 3) == 0);
            rx.waits  = $urandom_range(0, 19);
            rx.prdata = $urandom;
            rx.slverr = ($urandom_range(0, 3) == 0);
            rx.hold   = $urandom_range(0, 3);
            run_xfer(model(rx));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // global bound on run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1);
    end

endmodule
